// File: rtl/ras_ckpt_if.sv
// Request/response bundle of the checkpointed return address stack.
// The predictor side drives push/pop/restore; the stack side drives the top-of-stack view.
interface ras_ckpt_if #(
    parameter int RAS_ENTRIES     = 16,
    parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
    parameter int PC_WIDTH        = 38,
    parameter int CNT_WIDTH       = $clog2(RAS_ENTRIES + 1)
);
    logic                       push_valid;
    logic [PC_WIDTH-1:0]        push_pc38;
    logic                       pop_valid;
    logic                       restore_valid;
    logic [LOG_RAS_ENTRIES-1:0] restore_idx;
    logic [CNT_WIDTH-1:0]       restore_cnt;
    logic                       restore_write_top;
    logic [PC_WIDTH-1:0]        restore_pc38;

    logic [PC_WIDTH-1:0]        tos_pc38;
    logic                       tos_valid;
    logic [LOG_RAS_ENTRIES-1:0] top_idx;
    logic [CNT_WIDTH-1:0]       cnt;
    logic                       full;
    logic                       overflow;

    modport master (
        output push_valid, push_pc38, pop_valid,
        output restore_valid, restore_idx, restore_cnt, restore_write_top, restore_pc38,
        input  tos_pc38, tos_valid, top_idx, cnt, full, overflow
    );

    modport slave (
        input  push_valid, push_pc38, pop_valid,
        input  restore_valid, restore_idx, restore_cnt, restore_write_top, restore_pc38,
        output tos_pc38, tos_valid, top_idx, cnt, full, overflow
    );
endinterface

// File: rtl/ras_ckpt.sv
// Circular return address stack with saturating occupancy, in-place pop+push replace,
// and checkpoint restore of top index/count with optional repair of the restored top.
module ras_ckpt #(
    parameter int RAS_ENTRIES     = 16,
    parameter int LOG_RAS_ENTRIES = $clog2(RAS_ENTRIES),
    parameter int PC_WIDTH        = 38,
    parameter int CNT_WIDTH       = $clog2(RAS_ENTRIES + 1)
) (
    input  logic      CLK,
    input  logic      nRST,
    ras_ckpt_if.slave ras
);

    localparam logic [CNT_WIDTH-1:0]       FULL_CNT  = CNT_WIDTH'(RAS_ENTRIES);
    localparam logic [LOG_RAS_ENTRIES-1:0] RESET_TOP = LOG_RAS_ENTRIES'(RAS_ENTRIES - 1);

    logic [PC_WIDTH-1:0]        entry_q [RAS_ENTRIES];
    logic [LOG_RAS_ENTRIES-1:0] top_q, top_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       ovf_q, ovf_d;

    logic                       wr_en;
    logic [LOG_RAS_ENTRIES-1:0] wr_idx;
    logic [PC_WIDTH-1:0]        wr_data;

    logic is_full, is_empty;
    assign is_full  = (cnt_q == FULL_CNT);
    assign is_empty = (cnt_q == '0);

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        top_d   = top_q;
        cnt_d   = cnt_q;
        ovf_d   = 1'b0;
        wr_en   = 1'b0;
        wr_idx  = top_q;
        wr_data = ras.push_pc38;

        if (ras.restore_valid) begin
            top_d   = ras.restore_idx;
            cnt_d   = ras.restore_cnt;
            wr_en   = ras.restore_write_top;
            wr_idx  = ras.restore_idx;
            wr_data = ras.restore_pc38;
        end else if (ras.push_valid && ras.pop_valid && !is_empty) begin
            wr_en = 1'b1;
        end else if (ras.push_valid) begin
            // Wrapping onto a full stack silently overwrites the oldest return target.
            top_d  = top_q + 1'b1;
            wr_en  = 1'b1;
            wr_idx = top_q + 1'b1;
            if (is_full) ovf_d = 1'b1;
            else         cnt_d = cnt_q + 1'b1;
        end else if (ras.pop_valid && !is_empty) begin
            top_d = top_q - 1'b1;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        // NOTE: registered state uses non-blocking assignments so all flops update together.
        if (!nRST) begin
            top_q <= RESET_TOP;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    // NOTE: the array is reset because a stale top is architecturally visible via tos_pc38.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < RAS_ENTRIES; i++) entry_q[i] <= '0;
        end else if (wr_en) begin
            entry_q[wr_idx] <= wr_data;
        end
    end

    assign ras.tos_pc38  = entry_q[top_q];
    assign ras.tos_valid = !is_empty;
    assign ras.top_idx   = top_q;
    assign ras.cnt       = cnt_q;
    assign ras.full      = is_full;
    assign ras.overflow  = ovf_q;

    restore_cnt_legal: assert property (@(posedge CLK) disable iff (!nRST)
        ras.restore_valid |-> ras.restore_cnt <= FULL_CNT);

endmodule
